// File: rtl/cache_set_ctrl_pkg.sv
// Shared types and default widths for the cache set controller and the set it drives.
package cache_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_LINE_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM_REQ,
    MEM_WAIT,
    FILL_ISSUE,
    FILL_WAIT,
    RESP
  } ctrl_state_t;

endpackage

// File: rtl/cache_set_ctrl_if.sv
// CPU request port, set channel-1 pins and memory port bundled as one bus.
interface cache_set_ctrl_if
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_write;
  logic [LINE_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [LINE_WIDTH-1:0] resp_data;
  logic                  resp_err;

  logic [ADDR_WIDTH-1:0] set_addr;
  logic [LINE_WIDTH-1:0] set_val;
  logic                  set_read;
  logic                  set_write;
  logic                  set_hit;
  logic [LINE_WIDTH-1:0] set_out_val;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_write;
  logic [LINE_WIDTH-1:0] mem_req_wdata;
  logic                  mem_resp_valid;
  logic [LINE_WIDTH-1:0] mem_resp_data;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata,
    input  set_hit, set_out_val,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data, resp_err,
    output set_addr, set_val, set_read, set_write,
    output mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata,
    output set_hit, set_out_val,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  set_addr, set_val, set_read, set_write,
    input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata
  );

endinterface

// File: rtl/cache_set_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_set_ctrl.sv
// Request-side controller for a K-way cache set: lookup, miss fetch, write-through
// with allocate, fill handshake with timeout, and hit/miss statistics.
module cache_set_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
  parameter int FILL_TIMEOUT = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  cache_set_ctrl_if.master     bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int            FW        = $clog2(FILL_TIMEOUT + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(FILL_TIMEOUT - 1);

  ctrl_state_t           state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] data_q;
  logic                  write_q;
  logic                  err_q;
  logic [FW-1:0]         fill_cnt;
  logic                  hit_inc;
  logic                  miss_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      fill_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            write_q <= bus.req_write;
            data_q  <= bus.req_wdata;
            state   <= bus.req_write ? MEM_REQ : LOOKUP;
          end
        end
        LOOKUP: state <= CHECK;
        CHECK: begin
          if (bus.set_hit) begin
            data_q <= bus.set_out_val;
            state  <= RESP;
          end else begin
            state <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (bus.mem_req_ready) state <= write_q ? FILL_ISSUE : MEM_WAIT;
        end
        MEM_WAIT: begin
          if (bus.mem_resp_valid) begin
            data_q <= bus.mem_resp_data;
            state  <= FILL_ISSUE;
          end
        end
        // set_hit is stale from the previous transaction here, so it is not looked at
        FILL_ISSUE: begin
          fill_cnt <= '0;
          state    <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (bus.set_hit) begin
            state <= RESP;
          end else if (fill_cnt == FILL_LAST) begin
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            fill_cnt <= fill_cnt + FW'(1);
          end
        end
        RESP: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hit_inc  = (state == CHECK) && bus.set_hit;
  assign miss_inc = (state == CHECK) && !bus.set_hit;

  // Every data/address output is gated so IDLE presents all zeros.
  assign bus.req_ready     = (state == IDLE);
  assign bus.set_read      = (state == LOOKUP);
  assign bus.set_write     = (state == FILL_ISSUE) || (state == FILL_WAIT);
  assign bus.set_addr      = (bus.set_read || bus.set_write) ? addr_q : '0;
  assign bus.set_val       = bus.set_write ? data_q : '0;
  assign bus.mem_req_valid = (state == MEM_REQ);
  assign bus.mem_req_addr  = bus.mem_req_valid ? addr_q : '0;
  assign bus.mem_req_write = bus.mem_req_valid && write_q;
  assign bus.mem_req_wdata = bus.mem_req_valid ? data_q : '0;
  assign bus.resp_valid    = (state == RESP);
  assign bus.resp_data     = bus.resp_valid ? data_q : '0;
  assign bus.resp_err      = bus.resp_valid && err_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (hit_inc),
    .count   (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (miss_inc),
    .count   (miss_count)
  );

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Bench for cache_set_ctrl: behavioural 2-way set, memory with stalls, and a
// transaction-level reference checked every cycle.
module tb_cache_set_ctrl;
  import cache_pkg::*;

  localparam int AW = 8;
  localparam int LW = 32;
  localparam int FT = 8;
  localparam int CW = 3;
  localparam int K  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  cache_set_ctrl_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();
  logic [CW-1:0] hit_count, miss_count;

  cache_set_ctrl #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FILL_TIMEOUT(FT), .CNT_WIDTH(CW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus.master),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int vec = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    vec++;
    errs++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural set: K ways, clock-sweep replacement ----------------
  logic          set_broken = 1'b0;
  logic          st_v   [K];
  logic [AW-1:0] st_tag [K];
  logic [LW-1:0] st_dat [K];
  logic          st_ref [K];
  int            st_ptr = 0;
  logic          stub_hit = 1'b0;
  logic [LW-1:0] stub_val = '0;

  initial for (int i = 0; i < K; i++) begin
    st_v[i] = 1'b0; st_tag[i] = '0; st_dat[i] = '0; st_ref[i] = 1'b0;
  end

  function automatic int stub_find(input logic [AW-1:0] a);
    for (int i = 0; i < K; i++) if (st_v[i] && st_tag[i] == a) return i;
    return -1;
  endfunction

  assign bus.set_hit     = set_broken ? 1'b0 : stub_hit;
  assign bus.set_out_val = stub_val;

  always @(posedge clock) begin
    int f;
    f = stub_find(bus.set_addr);
    if (bus.set_read) begin
      stub_hit <= (f >= 0);
      if (f >= 0) begin stub_val <= st_dat[f]; st_ref[f] = 1'b1; end
    end else if (bus.set_write && !set_broken) begin
      if (f >= 0) begin
        st_dat[f] = bus.set_val;
        stub_hit <= 1'b1;
      end else begin
        stub_hit <= 1'b0;
        if (!st_v[st_ptr] || !st_ref[st_ptr]) begin
          st_v[st_ptr] = 1'b1; st_tag[st_ptr] = bus.set_addr;
          st_dat[st_ptr] = bus.set_val; st_ref[st_ptr] = 1'b1;
        end else begin
          st_ref[st_ptr] = 1'b0;
        end
        st_ptr = (st_ptr + 1) % K;
      end
    end
  end

  // ---------------- memory: ready unless stalled, fetch data 2 cycles after accept ----------------
  logic [LW-1:0] gmem [256];
  int            mem_pend = 0;
  logic [LW-1:0] mem_pend_data;
  logic          mem_ready_en = 1'b1;
  logic          rand_stall = 1'b0;
  logic          junk_en = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      mem_pend = 0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
    end else begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data = $urandom;
      if (mem_pend > 0) begin
        mem_pend--;
        if (mem_pend == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data = mem_pend_data;
        end
      end else if (junk_en && $urandom_range(0, 3) == 0) begin
        bus.mem_resp_valid = 1'b1;  // stray beat, must be ignored
      end
      bus.mem_req_ready = mem_ready_en && !(rand_stall && $urandom_range(0, 2) == 0);
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (bus.mem_req_write) gmem[bus.mem_req_addr] = bus.mem_req_wdata;
        else begin mem_pend = 2; mem_pend_data = gmem[bus.mem_req_addr]; end
      end
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  int            cyc = 0;
  logic          busy = 1'b0;
  logic [AW-1:0] c_addr;
  logic          c_write, c_hit, c_err;
  logic [LW-1:0] c_data;
  int            c_acc, sw_cnt, sw_last, mreq_cycles;
  logic          mem_seen;
  int            exp_hits = 0, exp_misses = 0;
  int            resp_done = 0;
  logic [LW-1:0] last_data;
  logic          last_err, last_mem_seen;
  int            last_lat, last_sw, last_mreq;

  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      busy = 1'b0; exp_hits = 0; exp_misses = 0;
    end else begin
      chk("req_ready", bus.req_ready, !busy);
      chk("rd_wr_excl", bus.set_read && bus.set_write, 1'b0);
      if (bus.req_ready)
        chk("idle_outputs", {bus.set_read, bus.set_write, bus.mem_req_valid, bus.mem_req_write,
                             bus.resp_valid, bus.resp_err, |bus.set_addr, |bus.set_val,
                             |bus.mem_req_addr, |bus.mem_req_wdata, |bus.resp_data}, '0);
      if (!busy && bus.req_valid && bus.req_ready) begin
        busy = 1'b1; c_addr = bus.req_addr; c_write = bus.req_write; c_acc = cyc;
        sw_cnt = 0; mem_seen = 1'b0; mreq_cycles = 0;
        if (c_write) begin
          c_hit = 1'b0; c_data = bus.req_wdata;
        end else begin
          c_hit = !set_broken && (stub_find(c_addr) >= 0);
          c_data = gmem[c_addr];
          if (c_hit) exp_hits = (exp_hits < CMAX) ? exp_hits + 1 : CMAX;
          else exp_misses = (exp_misses < CMAX) ? exp_misses + 1 : CMAX;
        end
        c_err = set_broken;
      end else if (busy) begin
        if (bus.set_read) chk("lookup_addr", bus.set_addr, c_addr);
        if (bus.set_write) begin
          chk("fill_addr", bus.set_addr, c_addr);
          chk("fill_val", bus.set_val, c_data);
          sw_cnt++; sw_last = cyc;
        end
        if (bus.mem_req_valid) begin
          mem_seen = 1'b1; mreq_cycles++;
          chk("mem_addr", bus.mem_req_addr, c_addr);
          chk("mem_write", bus.mem_req_write, c_write);
          if (c_write) chk("mem_wdata", bus.mem_req_wdata, c_data);
        end
        if (bus.resp_valid) begin
          chk("resp_data", bus.resp_data, c_data);
          chk("resp_err", bus.resp_err, c_err);
          chk("hit_count", hit_count, exp_hits);
          chk("miss_count", miss_count, exp_misses);
          chk("mem_used", mem_seen, c_write || !c_hit);
          if (c_hit) begin
            chk("hit_latency", cyc - c_acc, 3);
            chk("hit_no_fill", sw_cnt, 0);
          end else begin
            chk("resp_after_fill", cyc - sw_last, 1);
            if (c_err) chk("timeout_fill_cycles", sw_cnt, FT + 1);
            else chk("fill_cycles_2_to_5", (sw_cnt >= 2) && (sw_cnt <= 5), 1'b1);
          end
          last_data = bus.resp_data; last_err = bus.resp_err; last_mem_seen = mem_seen;
          last_lat = cyc - c_acc; last_sw = sw_cnt; last_mreq = mreq_cycles;
          busy = 1'b0; resp_done++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] d);
    int n = 0;
    @(posedge clock); #2;
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_write = w; bus.req_wdata = d;
    forever begin
      @(negedge clock); #1;
      if (bus.req_ready) break;
      if (++n > 100) begin bound_fail("accept_wait"); break; end
    end
    @(posedge clock); #2;
    bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_write = $urandom; bus.req_wdata = $urandom;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (resp_done < target) begin
      @(negedge clock); #1;
      if (++n > 200) begin bound_fail("resp_wait"); break; end
    end
  endtask

  task automatic xact(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] d);
    int t;
    t = resp_done + 1;
    issue(a, w, d);
    wait_done(t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_wdata = '0;
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    for (int i = 0; i < 256; i++) gmem[i] = $urandom;
    gmem[8'h10] = 32'hDEADBEEF;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_outputs", {bus.resp_valid, bus.mem_req_valid, bus.set_read, bus.set_write}, '0);
    chk("rst_counts", {hit_count, miss_count}, '0);
    reset_n = 1'b1;

    // cold miss then hit on 0x10
    xact(8'h10, 1'b0, $urandom);
    chk("cold_data", last_data, 32'hDEADBEEF);
    chk("cold_err", last_err, 1'b0);
    chk("cold_miss_count", miss_count, 1);
    chk("cold_used_mem", last_mem_seen, 1'b1);
    xact(8'h10, 1'b0, $urandom);
    chk("rehit_data", last_data, 32'hDEADBEEF);
    chk("rehit_latency", last_lat, 3);
    chk("rehit_hit_count", hit_count, 1);
    chk("rehit_no_mem", last_mem_seen, 1'b0);

    // write-through with allocate, then read back
    xact(8'h20, 1'b1, 32'h12345678);
    chk("wr_echo", last_data, 32'h12345678);
    chk("wr_one_mem_req", last_mreq, 1);
    xact(8'h20, 1'b0, $urandom);
    chk("wr_readback", last_data, 32'h12345678);
    chk("wr_readback_hits", hit_count, 2);

    // three fills into two ways; third one sweeps both reference bits
    xact(8'h01, 1'b0, $urandom);
    xact(8'h02, 1'b0, $urandom);
    xact(8'h03, 1'b0, $urandom);
    chk("evict_err", last_err, 1'b0);
    chk("evict_fill_cycles", last_sw, 5);
    xact(8'h03, 1'b0, $urandom);
    chk("evict_rehit", hit_count, 3);
    chk("evict_misses", miss_count, 4);

    // memory stall during a miss
    mem_ready_en = 1'b0;
    t = resp_done + 1;
    issue(8'h40, 1'b0, $urandom);
    n = 0;
    while (!bus.mem_req_valid && n < 50) begin @(negedge clock); #1; n++; end
    if (n >= 50) bound_fail("stall_req_wait");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      chk("stall_valid", bus.mem_req_valid, 1'b1);
      chk("stall_addr", bus.mem_req_addr, 8'h40);
    end
    mem_ready_en = 1'b1;
    wait_done(t);
    chk("stall_data", last_data, gmem[8'h40]);

    // set never answers: fill times out
    set_broken = 1'b1;
    xact(8'h55, 1'b0, $urandom);
    chk("timeout_err", last_err, 1'b1);
    chk("timeout_fill_cycles_lit", last_sw, 9);
    set_broken = 1'b0;

    // reset while waiting on memory
    issue(8'hF0, 1'b0, $urandom);
    n = 0;
    while (!bus.mem_req_valid && n < 50) begin @(negedge clock); #1; n++; end
    if (n >= 50) bound_fail("reset_req_wait");
    @(negedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_mem_valid", bus.mem_req_valid, 1'b0);
    chk("midrst_resp_valid", bus.resp_valid, 1'b0);
    chk("midrst_counts", {hit_count, miss_count}, '0);
    chk("midrst_ready", bus.req_ready, 1'b1);
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;
    xact(8'h10, 1'b0, $urandom);
    chk("postrst_data", last_data, 32'hDEADBEEF);
    chk("postrst_miss_count", miss_count, 1);
    chk("postrst_hit_count", hit_count, 0);

    // randomized traffic over a small address pool, stalls and stray memory beats
    junk_en = 1'b1;
    rand_stall = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [AW-1:0] a;
      logic          w;
      a = 8'h80 + 8'($urandom_range(0, 5));
      w = ($urandom_range(0, 9) < 3);
      xact(a, w, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/cache_set_ctrl.md
Name: cache_set_ctrl

Overview:
Request-side controller for the K-way cache set: it initiates the set's channel-1 read/write protocol and responds to one CPU-side requester. Reads are looked up in the set; a miss fetches from backing memory and is filled into the set. Writes are write-through and write-allocate. It sits between the CPU port, the set's ch1 pins and the memory port, and keeps hit/miss statistics.

Parameters:
ADDR_WIDTH, 8, address width; must match the set.
LINE_WIDTH, 32, data width; must match the set.
FILL_TIMEOUT, 8, maximum FILL_WAIT cycles before error; must be at least 2*K of the attached set.
CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  controller idle; high exactly when state==IDLE
req_addr  in  ADDR_WIDTH  request address
req_write  in  1  1=write, 0=read
req_wdata  in  LINE_WIDTH  write data
resp_valid  out  1  one-cycle completion pulse
resp_data  out  LINE_WIDTH  read data; write data echoed on writes
resp_err  out  1  fill timed out
set_addr  out  ADDR_WIDTH  to set ch1_in_addr
set_val  out  LINE_WIDTH  to set ch1_in_val
set_read  out  1  to set ch1_read
set_write  out  1  to set ch1_write
set_hit  in  1  from set ch1_hit (registered in set)
set_out_val  in  LINE_WIDTH  from set ch1_out_val
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_WIDTH  memory address
mem_req_write  out  1  1=write-through, 0=fetch
mem_req_wdata  out  LINE_WIDTH  write-through data
mem_resp_valid  in  1  fetch data valid (single beat; writes get no response)
mem_resp_data  in  LINE_WIDTH  fetch data
hit_count  out  CNT_WIDTH  saturating count of read hits
miss_count  out  CNT_WIDTH  saturating count of read misses

Behaviour:
- Clocking and reset: one clock. reset_n is asynchronous and active-low.
- Reset values: state=IDLE; latched addr, data and write flag=0; fill counter=0; hit_count=miss_count=0.
- Output values in reset and IDLE: all outputs 0 except req_ready=1.
- Output timing: set_*, mem_req_*, resp_* and req_ready decode combinationally from state and latched registers. No request is accepted on an edge where reset_n is low.
- IDLE: when req_valid is high, latch addr, write flag and wdata. A read goes to LOOKUP; a write goes to MEM_REQ.
- LOOKUP (1 cycle): set_read=1, set_addr=latched addr. Go to CHECK.
- CHECK (1 cycle): sample set_hit and set_out_val.
  - Hit: latch set_out_val into the data register, increment hit_count, go to RESP.
  - Miss: increment miss_count, go to MEM_REQ.
- Counters: saturate at all-ones.
- MEM_REQ: mem_req_valid=1, with addr, write flag and data held stable until the accepting edge (mem_req_valid && mem_req_ready).
  - After acceptance, a read goes to MEM_WAIT and a write goes to FILL_ISSUE.
  - A stalled mem_req_ready holds the state indefinitely.
- MEM_WAIT: on mem_resp_valid, latch mem_resp_data, go to FILL_ISSUE. mem_resp_valid outside MEM_WAIT is ignored.
- FILL_ISSUE (1 cycle): set_write=1, set_addr/set_val=latched values. Clear the fill counter. Go to FILL_WAIT.
  - set_hit is not sampled here, because it still holds a stale value from an earlier transaction.
- FILL_WAIT: set_write stays 1.
  - If set_hit==1, go to RESP.
  - Else, if the fill counter equals FILL_TIMEOUT-1, set the error flag and go to RESP.
  - Else, increment the fill counter.
  - The extra set write on the exit edge rewrites identical data to the same line; this is intentional and harmless.
- RESP (1 cycle): resp_valid=1, resp_data=latched data, resp_err=error flag. Clear the error flag, go to IDLE. There is no response backpressure; the requester must accept.
- set_read and set_write are never high in the same cycle.
- Reset mid-operation: the transaction is abandoned with no resp_valid, and mem_req_valid drops immediately.
  - The set has no reset, so its write FSM may be left mid-sweep. The next FILL still converges because the set continues its sweep, bounded by 2*K cycles.
- Read latency from the acceptance edge:
  - hit: resp_valid 3 cycles later;
  - miss: 3 + memory accept and response latency + 1 + n_fill cycles.

Decomposition:
- Package cache_pkg:
  - ctrl_state_t enum: IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL_ISSUE, FILL_WAIT, RESP;
  - default ADDR_WIDTH/LINE_WIDTH localparams shared with the set.
- Sub-module sat_counter (parameter WIDTH; ports clock, reset_n, inc, count), instantiated twice for hit_count and miss_count.

Test Plan:
- Bench setup: controller wired to the set with K=2, and a memory model with 1-cycle ready and a 2-cycle fetch response.
- Cold read of addr 0x10, memory returns 0xDEADBEEF -> miss_count=1, mem_req_write=0; resp_valid with resp_data=0xDEADBEEF, resp_err=0. A repeat read of 0x10 -> hit, resp_valid exactly 3 cycles after acceptance, hit_count=1, no mem_req_valid.
- Write 0x20 with 0x12345678 -> one mem_req with mem_req_write=1 and data 0x12345678; resp_valid with echoed data. Then read 0x20 -> hit returning 0x12345678.
- Fill three distinct addresses 0x01, 0x02, 0x03 into the K=2 set -> third fill evicts via the clock sweep within 4 FILL_WAIT cycles, resp_err=0. Reading 0x03 hits.
- Hold mem_req_ready low for 10 cycles during a miss -> mem_req_valid and mem_req_addr stay stable throughout; completion follows release.
- Set stub that never raises set_hit, FILL_TIMEOUT=8 -> resp_valid with resp_err=1 exactly 8 cycles after FILL_WAIT entry. req_ready returns high the next cycle.
- Assert reset_n low during MEM_WAIT -> mem_req_valid, resp_valid and counters read 0 immediately; req_ready=1. A subsequent read of 0x10 completes normally.
